// File: rtl/kp_voice_allocator.sv
// Polyphonic note scheduler for Karplus-Strong string voices: accepts note
// requests, picks a free voice (or steals the one nearest expiry), loads its
// length/octave and fires an active-low trigger pulse on it.
module kp_voice_allocator #(
    parameter int unsigned NUM_VOICES  = 4,
    parameter int unsigned LIFE_W      = 8,
    parameter int unsigned HOLD_TICKS  = 200,
    parameter int unsigned TRIG_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic [8:0]              note_len,
    input  logic [1:0]              note_oct,
    output logic [NUM_VOICES-1:0]   voice_trig_n,
    output logic [9*NUM_VOICES-1:0] voice_len,
    output logic [2*NUM_VOICES-1:0] voice_oct,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic [2:0]              alloc_idx,
    output logic                    stole,
    output logic                    drop
);

    localparam int unsigned CntMax = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 2);
    localparam logic [LIFE_W-1:0] Hold = LIFE_W'(HOLD_TICKS);

    typedef enum logic [2:0] {StIdle, StSelect, StAssign, StTrig, StGap} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [8:0]              req_len_q;
    logic [1:0]              req_oct_q;
    logic [2:0]              sel_q;
    logic [2:0]              alloc_q;
    logic                    stole_q;
    logic                    drop_q;
    logic [NUM_VOICES-1:0]   trig_n_q, trig_n_d;
    logic [LIFE_W-1:0]       life_q [NUM_VOICES];
    logic [LIFE_W-1:0]       life_d [NUM_VOICES];
    logic [8:0]              len_q  [NUM_VOICES];
    logic [1:0]              oct_q  [NUM_VOICES];

    logic                    xfer;
    logic                    free_found;
    logic [2:0]              pick_free;
    logic [2:0]              pick_min;
    logic [LIFE_W-1:0]       min_life;

    assign xfer = note_valid & note_ready;

    // Voice choice: lowest-index idle voice, else smallest life (ties to lowest index)
    always_comb begin
        free_found = 1'b0;
        pick_free  = 3'd0;
        pick_min   = 3'd0;
        min_life   = life_q[0];
        for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
            if (life_q[i] == '0) begin
                free_found = 1'b1;
                pick_free  = 3'(i);
            end
        end
        for (int i = 1; i < int'(NUM_VOICES); i++) begin
            if (life_q[i] < min_life) begin
                min_life = life_q[i];
                pick_min = 3'(i);
            end
        end
    end

    // FSM state and phase counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; GAP runs one extra cycle because the trigger output
    // is registered and is still low during the first GAP cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:   if (xfer && note_len != 9'd0) state_d = StSelect;
            StSelect: state_d = StAssign;
            StAssign: begin
                state_d = StTrig;
                cnt_d   = '0;
            end
            StTrig: begin
                if (cnt_q == CntW'(TRIG_CYCLES - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_CYCLES)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: ready in IDLE, one trigger lane low while in TRIG
    always_comb begin
        note_ready = (state_q == StIdle);
        trig_n_d   = '1;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (state_q == StTrig && sel_q == 3'(i)) trig_n_d[i] = 1'b0;
        end
    end

    // Life counters: ASSIGN load beats a coincident tick; decrement saturates at 0
    always_comb begin
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            life_d[i] = life_q[i];
            if (state_q == StAssign && sel_q == 3'(i)) begin
                life_d[i] = Hold;
            end else if (tick && life_q[i] != '0) begin
                life_d[i] = life_q[i] - 1'b1;
            end
        end
    end

    // Datapath registers: request latch, selection, per-voice settings, pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_len_q <= '0;
            req_oct_q <= '0;
            sel_q     <= '0;
            alloc_q   <= '0;
            stole_q   <= 1'b0;
            drop_q    <= 1'b0;
            trig_n_q  <= '1;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                life_q[i] <= '0;
                len_q[i]  <= '0;
                oct_q[i]  <= '0;
            end
        end else begin
            trig_n_q <= trig_n_d;
            drop_q   <= xfer && (note_len == 9'd0);
            stole_q  <= (state_q == StSelect) && !free_found;
            if (xfer) begin
                req_len_q <= note_len;
                req_oct_q <= note_oct;
            end
            if (state_q == StSelect) sel_q <= free_found ? pick_free : pick_min;
            if (state_q == StAssign) alloc_q <= sel_q;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                life_q[i] <= life_d[i];
                if (state_q == StAssign && sel_q == 3'(i)) begin
                    len_q[i] <= req_len_q;
                    oct_q[i] <= req_oct_q;
                end
            end
        end
    end

    // Flatten per-voice state onto the output buses
    always_comb begin
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            voice_len[9*i +: 9] = len_q[i];
            voice_oct[2*i +: 2] = oct_q[i];
            voice_busy[i]       = (life_q[i] != '0);
        end
    end

    assign voice_trig_n = trig_n_q;
    assign alloc_idx    = alloc_q;
    assign stole        = stole_q;
    assign drop         = drop_q;

endmodule

// File: tb/tb_kp_voice_allocator.sv
// Directed bench for kp_voice_allocator: expected allocations are queued when
// a note is driven and compared when the trigger pulse appears.
module tb_kp_voice_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [8:0]  note_len = '0;
    logic [1:0]  note_oct = '0;
    logic [3:0]  voice_trig_n;
    logic [35:0] voice_len;
    logic [7:0]  voice_oct;
    logic [3:0]  voice_busy;
    logic [2:0]  alloc_idx;
    logic        stole;
    logic        drop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] idx;
        logic [8:0] len;
        logic [1:0] oct;
        logic       st;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] mdl_len [4];
    logic [1:0] mdl_oct [4];

    kp_voice_allocator #(
        .NUM_VOICES (4),
        .LIFE_W     (8),
        .HOLD_TICKS (200),
        .TRIG_CYCLES(16),
        .GAP_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_len    (note_len),
        .note_oct    (note_oct),
        .voice_trig_n(voice_trig_n),
        .voice_len   (voice_len),
        .voice_oct   (voice_oct),
        .voice_busy  (voice_busy),
        .alloc_idx   (alloc_idx),
        .stole       (stole),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_trig",  64'(voice_trig_n), 64'hf);
        check("rst_len",   64'(voice_len), 64'h0);
        check("rst_oct",   64'(voice_oct), 64'h0);
        check("rst_busy",  64'(voice_busy), 64'h0);
        check("rst_ready", 64'(note_ready), 64'h1);
        check("rst_idx",   64'(alloc_idx), 64'h0);
        check("rst_stole", 64'(stole), 64'h0);
        check("rst_drop",  64'(drop), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mdl_len[i] = '0;
            mdl_oct[i] = '0;
        end
        check_reset_state();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // Drive one note and follow it until the allocator is ready again.
    // k counts falling edges after the transfer edge (k=0 is the first).
    task automatic do_note(input logic [8:0] len, input logic [1:0] oct,
                           input logic [2:0] idx, input logic st, input logic tick_assign);
        exp_t       e;
        int         first_trig;
        int         low_cnt;
        int         first_ready;
        int         stole_cnt;
        logic [3:0] pat;
        logic [3:0] exp_pat;
        @(negedge clk);
        check("ready_before", 64'(note_ready), 64'h1);
        note_valid = 1'b1;
        note_len   = len;
        note_oct   = oct;
        sb.push_back('{idx: idx, len: len, oct: oct, st: st});
        @(posedge clk);
        first_trig  = -1;
        low_cnt     = 0;
        first_ready = -1;
        stole_cnt   = 0;
        pat         = 4'hf;
        for (int k = 0; k < 80 && first_ready < 0; k++) begin
            @(negedge clk);
            note_valid = 1'b0;
            // k==1 drive lands on the edge that ends the ASSIGN cycle
            tick = tick_assign && (k == 1);
            if (stole) stole_cnt++;
            if (voice_trig_n != 4'hf) begin
                if (first_trig < 0) begin
                    first_trig = k;
                    pat        = voice_trig_n;
                end
                if (voice_trig_n == pat) low_cnt++;
            end
            if (note_ready) first_ready = k;
        end
        tick = 1'b0;
        e = sb.pop_front();
        exp_pat        = 4'hf;
        exp_pat[e.idx] = 1'b0;
        mdl_len[e.idx] = e.len;
        mdl_oct[e.idx] = e.oct;
        check("trig_latency", 64'(first_trig), 64'(3));
        check("trig_width",   64'(low_cnt), 64'(16));
        check("trig_lane",    64'(pat), 64'(exp_pat));
        check("ready_low",    64'(first_ready), 64'(35));
        check("stole_pulse",  64'(stole_cnt), 64'(e.st));
        check("alloc_idx",    64'(alloc_idx), 64'(e.idx));
        check("busy_sel",     64'(voice_busy[e.idx]), 64'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("len_lane%0d", i), 64'(voice_len[9*i +: 9]), 64'(mdl_len[i]));
            check($sformatf("oct_lane%0d", i), 64'(voice_oct[2*i +: 2]), 64'(mdl_oct[i]));
        end
    endtask

    initial begin
        int drop_cnt;
        int trig_cnt;
        int nready_cnt;

        // Asynchronous reset from power-up
        reset = 1'b1;
        #3;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mdl_len[i] = '0;
            mdl_oct[i] = '0;
        end
        check_reset_state();

        // First request lands on voice 0
        do_note(9'd100, 2'd1, 3'd0, 1'b0, 1'b0);

        // Life expiry after 200 ticks, saturation at zero
        tick_n(199);
        check("busy_199", 64'(voice_busy), 64'h1);
        tick_n(1);
        check("busy_200", 64'(voice_busy), 64'h0);
        tick_n(3);
        check("busy_sat", 64'(voice_busy), 64'h0);

        // Tick during ASSIGN: the load wins, so life is a full 200
        do_note(9'd120, 2'd2, 3'd0, 1'b0, 1'b1);
        tick_n(199);
        check("assign_tick_199", 64'(voice_busy), 64'h1);
        tick_n(1);
        check("assign_tick_200", 64'(voice_busy), 64'h0);

        // Zero-length request is dropped without leaving IDLE
        @(negedge clk);
        note_valid = 1'b1;
        note_len   = 9'd0;
        note_oct   = 2'd1;
        @(negedge clk);
        note_valid = 1'b0;
        check("drop_pulse", 64'(drop), 64'h1);
        check("drop_ready", 64'(note_ready), 64'h1);
        drop_cnt   = 0;
        trig_cnt   = 0;
        nready_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (drop) drop_cnt++;
            if (voice_trig_n != 4'hf) trig_cnt++;
            if (!note_ready) nready_cnt++;
        end
        check("drop_single", 64'(drop_cnt), 64'h0);
        check("drop_no_trig", 64'(trig_cnt), 64'h0);
        check("drop_no_busy", 64'(nready_cnt), 64'h0);

        // Four requests fill voices 0..3 in order
        do_reset();
        do_note(9'd50, 2'd0, 3'd0, 1'b0, 1'b0);
        do_note(9'd60, 2'd1, 3'd1, 1'b0, 1'b0);
        do_note(9'd70, 2'd2, 3'd2, 1'b0, 1'b0);
        do_note(9'd80, 2'd3, 3'd3, 1'b0, 1'b0);
        check("busy_all", 64'(voice_busy), 64'hf);
        // Equal lives everywhere: the steal ties to voice 0
        do_note(9'd55, 2'd1, 3'd0, 1'b1, 1'b0);

        // Stagger lives so voice 2 ends up closest to expiry
        do_reset();
        do_note(9'd11, 2'd0, 3'd0, 1'b0, 1'b0);
        tick_n(40);
        do_note(9'd12, 2'd1, 3'd1, 1'b0, 1'b0);
        tick_n(40);
        do_note(9'd13, 2'd2, 3'd2, 1'b0, 1'b0);
        tick_n(40);
        do_note(9'd14, 2'd3, 3'd3, 1'b0, 1'b0);
        tick_n(120);
        check("busy_stagger", 64'(voice_busy), 64'hc);
        do_note(9'd15, 2'd0, 3'd0, 1'b0, 1'b0);
        do_note(9'd16, 2'd1, 3'd1, 1'b0, 1'b0);
        check("busy_full", 64'(voice_busy), 64'hf);
        do_note(9'd90, 2'd3, 3'd2, 1'b1, 1'b0);

        // Reset in the middle of a trigger pulse
        do_reset();
        @(negedge clk);
        note_valid = 1'b1;
        note_len   = 9'd33;
        note_oct   = 2'd2;
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_trig_low", 64'(voice_trig_n), 64'he);
        #2;
        reset = 1'b1;
        #1;
        check("async_trig", 64'(voice_trig_n), 64'hf);
        check("async_busy", 64'(voice_busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        check("post_ready", 64'(note_ready), 64'h1);
        trig_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (voice_trig_n != 4'hf) trig_cnt++;
        end
        check("post_no_trig", 64'(trig_cnt), 64'h0);
        check("post_busy", 64'(voice_busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
